bcnn_fc_classifier: RTL and testbench

BCNN_FC_CLASSIFIER -- requirements
Module: bcnn_fc_classifier

---
 rtl/bcnn_fc_classifier.sv | 137 +++++++++++++
 tb/tb_bcnn_fc_classifier.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcnn_fc_classifier.sv
// Binary fully-connected classifier: XNOR-popcount scores per class, then a
// sequential argmax scan that reports the winning class and its score.
module bcnn_fc_classifier #(
  parameter int unsigned NUM_IN      = 25,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned CNT_WIDTH   = 5,
  parameter int unsigned CLASS_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pixel_in,
  input  logic                          valid_in,
  input  logic [NUM_CLASSES*NUM_IN-1:0] weight_bits,
  output logic                          in_ready,
  output logic [CLASS_WIDTH-1:0]        class_out,
  output logic [CNT_WIDTH-1:0]          score_out,
  output logic                          result_valid,
  output logic                          overrun
);

  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CLASS_WIDTH-1:0] j_q, j_d;
  logic [CNT_WIDTH-1:0]   score_q [NUM_CLASSES];
  logic [CNT_WIDTH-1:0]   score_d [NUM_CLASSES];
  logic [CLASS_WIDTH-1:0] best_cls_q, best_cls_d;
  logic [CNT_WIDTH-1:0]   best_score_q, best_score_d;
  logic [CLASS_WIDTH-1:0] class_q, class_d;
  logic [CNT_WIDTH-1:0]   score_out_q, score_out_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic [NUM_IN-1:0]      w_row;
  logic                   scan_hit;
  logic [CLASS_WIDTH-1:0] cand_cls;
  logic [CNT_WIDTH-1:0]   cand_score;

  assign in_ready     = (state_q == ST_ACCUM);
  assign class_out    = class_q;
  assign score_out    = score_out_q;
  assign result_valid = valid_q;
  assign overrun      = overrun_q;

  // Next-state and datapath update; the first scanned class always seeds the best.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    j_d          = j_q;
    score_d      = score_q;
    best_cls_d   = best_cls_q;
    best_score_d = best_score_q;
    class_d      = class_q;
    score_out_d  = score_out_q;
    valid_d      = 1'b0;
    overrun_d    = overrun_q | (valid_in && (state_q != ST_ACCUM));
    w_row        = '0;

    scan_hit   = (j_q == '0) || (score_q[j_q] > best_score_q);
    cand_cls   = scan_hit ? j_q : best_cls_q;
    cand_score = scan_hit ? score_q[j_q] : best_score_q;

    case (state_q)
      ST_ACCUM: begin
        if (valid_in) begin
          for (int k = 0; k < int'(NUM_CLASSES); k++) begin
            w_row = weight_bits[k*NUM_IN +: NUM_IN];
            if ((pixel_in ~^ w_row[idx_q]) && (score_q[k] != CNT_WIDTH'(NUM_IN))) begin
              score_d[k] = score_q[k] + CNT_WIDTH'(1);
            end
          end
          if (idx_q == IDX_W'(NUM_IN - 1)) begin
            idx_d   = '0;
            j_d     = '0;
            state_d = ST_SCAN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_SCAN: begin
        best_cls_d   = cand_cls;
        best_score_d = cand_score;
        if (j_q == CLASS_WIDTH'(NUM_CLASSES - 1)) begin
          j_d         = '0;
          class_d     = cand_cls;
          score_out_d = cand_score;
          valid_d     = 1'b1;
          state_d     = ST_OUT;
        end else begin
          j_d = j_q + CLASS_WIDTH'(1);
        end
      end
      ST_OUT: begin
        for (int k = 0; k < int'(NUM_CLASSES); k++) begin
          score_d[k] = '0;
        end
        state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ACCUM;
      idx_q        <= '0;
      j_q          <= '0;
      for (int k = 0; k < int'(NUM_CLASSES); k++) begin
        score_q[k] <= '0;
      end
      best_cls_q   <= '0;
      best_score_q <= '0;
      class_q      <= '0;
      score_out_q  <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      j_q          <= j_d;
      score_q      <= score_d;
      best_cls_q   <= best_cls_d;
      best_score_q <= best_score_d;
      class_q      <= class_d;
      score_out_q  <= score_out_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_bcnn_fc_classifier.sv
// Scoreboard bench for bcnn_fc_classifier: frames are modelled when driven,
// results are popped and compared when result_valid pulses.
module tb_bcnn_fc_classifier;

  localparam int NUM_IN      = 25;
  localparam int NUM_CLASSES = 10;
  localparam int CNT_WIDTH   = 5;
  localparam int CLASS_WIDTH = 4;
  localparam int WB          = NUM_CLASSES * NUM_IN;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   pixel_in = 1'b0;
  logic                   src_valid = 1'b0;
  logic                   gate_mode = 1'b1;
  logic                   valid_in;
  logic [WB-1:0]          weights = '0;
  logic                   in_ready;
  logic [CLASS_WIDTH-1:0] class_out;
  logic [CNT_WIDTH-1:0]   score_out;
  logic                   result_valid;
  logic                   overrun;

  typedef struct {
    int cls;
    int sc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  assign valid_in = src_valid & (~gate_mode | in_ready);

  bcnn_fc_classifier #(
    .NUM_IN(NUM_IN), .NUM_CLASSES(NUM_CLASSES),
    .CNT_WIDTH(CNT_WIDTH), .CLASS_WIDTH(CLASS_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .valid_in(valid_in),
    .weight_bits(weights), .in_ready(in_ready), .class_out(class_out),
    .score_out(score_out), .result_valid(result_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model(input logic [WB-1:0] w, input logic [NUM_IN-1:0] f,
                                output int cls, output int sc);
    int s;
    sc  = -1;
    cls = 0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      s = 0;
      for (int i = 0; i < NUM_IN; i++) if (f[i] == w[k*NUM_IN + i]) s++;
      if (s > sc) begin
        sc  = s;
        cls = k;
      end
    end
  endfunction

  // Result monitor: latency, pulse width, held outputs and scoreboard compare.
  int   acc_cnt = 0;
  int   cyc = 0;
  bit   armed = 0;
  bit   prev_rv = 0;
  int   last_cls = 0;
  int   last_sc = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!reset) begin
      acc_cnt = 0; armed = 0; cyc = 0; prev_rv = 0;
      last_cls = 0; last_sc = 0;
      sb.delete();
    end else begin
      if (armed) cyc++;
      if (prev_rv) check("rv_width", 32'(result_valid), 0);
      if (result_valid) begin
        if (sb.size() == 0) begin
          check("spurious_rv", 1, 0);
        end else begin
          e = sb.pop_front();
          check("class", 32'(class_out), e.cls);
          check("score", 32'(score_out), e.sc);
          check("latency", cyc, NUM_CLASSES + 1);
        end
        last_cls = class_out;
        last_sc  = score_out;
        armed    = 0;
      end else begin
        check("class_hold", 32'(class_out), last_cls);
        check("score_hold", 32'(score_out), last_sc);
      end
      if (valid_in && in_ready) begin
        acc_cnt++;
        if (acc_cnt == NUM_IN) begin
          acc_cnt = 0; armed = 1; cyc = 0;
        end
      end
      prev_rv = result_valid;
    end
  end

  // Drives nbits of frame f; pushes the expectation when the final bit is offered.
  task automatic send_frame(input logic [NUM_IN-1:0] f, input int nbits,
                            input bit gaps, input bit hold);
    int n = 0;
    int guard = 0;
    bit acc;
    exp_t x;
    while (n < nbits) begin
      if (guard++ > 4 * NUM_IN + 50) begin
        check("send_timeout", 1, 0);
        break;
      end
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        src_valid = 1'b0;
        acc = 1'b0;
      end else begin
        src_valid = 1'b1;
        pixel_in  = f[n];
        acc = in_ready;
      end
      if (acc && (n == NUM_IN - 1)) begin
        model(weights, f, x.cls, x.sc);
        sb.push_back(x);
      end
      @(posedge clk); #1;
      if (acc) n++;
    end
    if (!hold) src_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb.size() != 0) begin
      if (guard++ > 100) begin
        check("drain_timeout", 32'(sb.size()), 0);
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_class"}, 32'(class_out), 0);
    check({tag, "_score"}, 32'(score_out), 0);
    check({tag, "_rv"}, 32'(result_valid), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  logic [NUM_IN-1:0] alt;
  logic [NUM_IN-1:0] frm;

  initial begin
    for (int i = 0; i < NUM_IN; i++) alt[i] = (i % 2 == 0);

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk); #1;

    // All-ones weights and input: ten-way tie resolves to class 0 with 25.
    weights = '1;
    send_frame('1, NUM_IN, 0, 0);
    wait_drain();

    // Only class 7 matches an all-ones input.
    weights = '0;
    weights[7*NUM_IN +: NUM_IN] = '1;
    send_frame('1, NUM_IN, 1, 0);
    wait_drain();
    check("c7_class", 32'(class_out), 7);
    check("c7_score", 32'(score_out), 25);

    // Class 3 equals the alternating pattern, class 5 its inverse.
    weights = '0;
    weights[3*NUM_IN +: NUM_IN] = alt;
    weights[5*NUM_IN +: NUM_IN] = ~alt;
    send_frame(alt, NUM_IN, 1, 0);
    wait_drain();
    check("alt_class", 32'(class_out), 3);

    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < WB; b++) weights[b] = 1'($urandom);
      frm = NUM_IN'($urandom);
      send_frame(frm, NUM_IN, 1, 0);
      wait_drain();
    end

    // A bit offered during SCAN is dropped and flags overrun.
    check("ovr_pre", 32'(overrun), 0);
    frm = NUM_IN'($urandom);
    send_frame(frm, NUM_IN, 0, 0);
    repeat (3) @(posedge clk);
    #1 gate_mode = 1'b0; src_valid = 1'b1; pixel_in = 1'b1;
    @(posedge clk); #1;
    src_valid = 1'b0; gate_mode = 1'b1;
    check("ovr_set", 32'(overrun), 1);
    wait_drain();
    @(posedge clk); #1;
    check("ovr_ready_back", 32'(in_ready), 1);
    frm = NUM_IN'($urandom);
    send_frame(frm, NUM_IN, 1, 0);
    wait_drain();
    check("ovr_sticky", 32'(overrun), 1);

    // Reset after 12 accepted bits discards the partial frame.
    send_frame(NUM_IN'($urandom), 12, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_mid");
    reset = 1'b1;
    @(posedge clk); #1;
    frm = NUM_IN'($urandom);
    send_frame(frm, NUM_IN, 0, 0);
    wait_drain();

    // Reset during SCAN: no result pulse for the aborted frame.
    send_frame(NUM_IN'($urandom), NUM_IN, 0, 0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_scan");
    reset = 1'b1;
    repeat (NUM_CLASSES + 4) @(posedge clk);
    #1 check("rst_scan_quiet", 32'(class_out), 0);

    // Back-to-back frames with the source held valid and gated by in_ready.
    frm = NUM_IN'($urandom);
    send_frame(frm, NUM_IN, 0, 1);
    frm = ~frm;
    send_frame(frm, NUM_IN, 0, 0);
    wait_drain();
    check("b2b_overrun", 32'(overrun), 0);
    check("final_queue", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
